fwd_hazard_unit: RTL and testbench

Parametrised decode-stage hazard and forwarding unit for the 5-stage pipeline. It generalises the single-port RD forwarding mux to NPORTS read ports. It owns an internal E/M/W scoreboard of in-flight destination registers with Tnew countdown, and generates the D-stage stall. It also tracks a multi-cycle mult/div busy window, so the hazard logic no longer depends on per-stage judge codes computed elsewhere.

---
 rtl/fwd_hazard_unit.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Decode-stage hazard/forwarding unit: tracks in-flight destinations in E/M/W
// with a Tnew countdown, picks per-port forwarding sources and raises the D stall.
module fwd_hazard_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NPORTS = 2,
  parameter int MD_LAT = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [NPORTS*REG_AW-1:0] d_rs_addr,
  input  logic [NPORTS*2-1:0]      d_tuse,
  input  logic [NPORTS*DATA_W-1:0] d_rs_data,
  input  logic [REG_AW-1:0]        d_dst,
  input  logic [1:0]               d_tnew,
  input  logic                     d_is_md,
  input  logic                     md_start,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        e_data,
  input  logic [DATA_W-1:0]        m_data,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     stall,
  output logic [NPORTS*2-1:0]      fwd_sel,
  output logic [NPORTS*DATA_W-1:0] fwd_data
);

  localparam int MDW  = $clog2(MD_LAT + 1);
  localparam int NREC = 3;

  // Record index 0 = E (youngest), 1 = M, 2 = W (oldest)
  logic              r_vld  [NREC];
  logic [REG_AW-1:0] r_dst  [NREC];
  logic [1:0]        r_tnew [NREC];
  logic [MDW-1:0]    r_md_cnt;

  logic              w_md_stall;
  logic [NPORTS-1:0] w_port_stall;
  logic              w_e_load_vld;
  logic [1:0]        w_e_load_tnew;

  genvar gi, ri;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  assign w_e_load_vld  = d_valid & ~stall & ~flush;
  assign w_e_load_tnew = (d_tnew == 2'd3) ? 2'd2 : d_tnew;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREC; k++) begin
        r_vld[k]  <= 1'b0;
        r_dst[k]  <= '0;
        r_tnew[k] <= 2'd0;
      end
    end else begin
      for (int k = NREC - 1; k > 0; k--) begin
        r_vld[k]  <= r_vld[k-1];
        r_dst[k]  <= r_dst[k-1];
        r_tnew[k] <= dec_sat(r_tnew[k-1]);
      end
      r_vld[0]  <= w_e_load_vld;
      r_dst[0]  <= d_dst;
      r_tnew[0] <= w_e_load_tnew;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (md_start) begin
      r_md_cnt <= MDW'(MD_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MDW'(1);
    end
  end

  // md_start counts as busy in the same cycle so a following md op cannot slip in
  assign w_md_stall = d_valid & d_is_md & ((r_md_cnt != '0) | md_start);
  assign stall      = d_valid & ((|w_port_stall) | w_md_stall);

  for (gi = 0; gi < NPORTS; gi++) begin : g_port
    logic [REG_AW-1:0] w_rs;
    logic [1:0]        w_tuse;
    logic [NREC-1:0]   w_match;
    logic              w_hit;
    logic [1:0]        w_hit_tnew;
    logic [1:0]        w_src;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] w_fwd;

    assign w_rs   = d_rs_addr[gi*REG_AW +: REG_AW];
    assign w_tuse = d_tuse[gi*2 +: 2];

    for (ri = 0; ri < NREC; ri++) begin : g_match
      assign w_match[ri] = r_vld[ri] && (r_dst[ri] != '0) && (r_dst[ri] == w_rs);
    end

    // Scan oldest to youngest so the youngest match is the one that sticks
    always_comb begin
      w_hit      = 1'b0;
      w_hit_tnew = 2'd0;
      w_src      = 2'd0;
      for (int k = NREC - 1; k >= 0; k--) begin
        if (w_match[k]) begin
          w_hit      = 1'b1;
          w_hit_tnew = r_tnew[k];
          w_src      = 2'(k + 1);
        end
      end
    end

    assign w_port_stall[gi] = w_hit && (w_hit_tnew > w_tuse);
    assign w_sel            = (w_hit && (w_hit_tnew == 2'd0)) ? w_src : 2'd0;

    always_comb begin
      w_fwd = d_rs_data[gi*DATA_W +: DATA_W];
      case (w_sel)
        2'd1:    w_fwd = e_data;
        2'd2:    w_fwd = m_data;
        2'd3:    w_fwd = w_data;
        default: w_fwd = d_rs_data[gi*DATA_W +: DATA_W];
      endcase
    end

    assign fwd_sel[gi*2 +: 2]           = w_sel;
    assign fwd_data[gi*DATA_W +: DATA_W] = w_fwd;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a per-cycle vector table walked in order
// (records carry over between rows) plus a hand sequence for async reset mid md window.
module tb_fwd_hazard_unit;

  localparam logic [31:0] E_VAL = 32'h0000_3008;
  localparam logic [31:0] M_VAL = 32'h0000_1234;
  localparam logic [31:0] W_VAL = 32'hBEEF_0001;
  localparam logic [31:0] RS0   = 32'hAAAA_0001;
  localparam logic [31:0] RS1   = 32'h5555_0002;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [9:0]  d_rs_addr;
  logic [3:0]  d_tuse;
  logic [63:0] d_rs_data;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic        d_is_md;
  logic        md_start;
  logic        flush;
  logic [31:0] e_data;
  logic [31:0] m_data;
  logic [31:0] w_data;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [63:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .NPORTS(2), .MD_LAT(5)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs_addr(d_rs_addr),
    .d_tuse(d_tuse), .d_rs_data(d_rs_data), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .md_start(md_start), .flush(flush), .e_data(e_data),
    .m_data(m_data), .w_data(w_data), .stall(stall), .fwd_sel(fwd_sel),
    .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] ra0;
    logic [1:0] tu0;
    logic [4:0] ra1;
    logic [1:0] tu1;
    logic [4:0] dst;
    logic [1:0] tn;
    logic       md;
    logic       mds;
    logic       fl;
    logic       es;
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [4:0] ra0, input logic [1:0] tu0,
                     input logic [4:0] ra1, input logic [1:0] tu1,
                     input logic [4:0] dst, input logic [1:0] tn,
                     input logic md, input logic mds, input logic fl,
                     input logic es, input logic [1:0] e0, input logic [1:0] e1);
    vec_t t;
    t.v = v; t.ra0 = ra0; t.tu0 = tu0; t.ra1 = ra1; t.tu1 = tu1;
    t.dst = dst; t.tn = tn; t.md = md; t.mds = mds; t.fl = fl;
    t.es = es; t.e0 = e0; t.e1 = e1;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    d_valid   = t.v;
    d_rs_addr = {t.ra1, t.ra0};
    d_tuse    = {t.tu1, t.tu0};
    d_dst     = t.dst;
    d_tnew    = t.tn;
    d_is_md   = t.md;
    md_start  = t.mds;
    flush     = t.fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] rs, input logic [1:0] sel);
    case (sel)
      2'd1:    return E_VAL;
      2'd2:    return M_VAL;
      2'd3:    return W_VAL;
      default: return rs;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic es, input logic [1:0] e0,
                           input logic [1:0] e1);
    check({tag, " stall"}, {31'd0, stall}, {31'd0, es});
    check({tag, " sel0"}, {30'd0, fwd_sel[1:0]}, {30'd0, e0});
    check({tag, " sel1"}, {30'd0, fwd_sel[3:2]}, {30'd0, e1});
    check({tag, " data0"}, fwd_data[31:0], exp_data(RS0, e0));
    check({tag, " data1"}, fwd_data[63:32], exp_data(RS1, e1));
  endtask

  initial begin
    vec_t z;
    //  v  ra0 tu ra1 tu dst tn md mds fl | st s0 s1
    add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 0, 0);  // ALU -> $8
    add(1, 8, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);  // beq $8: E tnew=1
    add(1, 8, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0);  // from M
    add(1, 0, 0, 0, 0, 31, 0, 0, 0, 0,  0, 0, 0);  // jal
    add(1, 31, 0, 31, 2, 0, 0, 0, 0, 0, 0, 1, 1);  // both ports from E
    add(1, 0, 0, 31, 0, 9, 2, 0, 0, 0,  0, 0, 2);  // lw $9; $31 from M
    add(1, 9, 1, 31, 0, 0, 0, 0, 0, 0,  1, 0, 3);  // lw in E tnew2>1
    add(1, 9, 1, 31, 0, 0, 0, 0, 0, 0,  0, 0, 0);  // M tnew1, no stall
    add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0);  // from W
    add(1, 0, 0, 0, 0, 5, 0, 0, 0, 0,   0, 0, 0);
    add(1, 5, 0, 5, 0, 5, 0, 0, 0, 0,   0, 1, 1);
    add(1, 5, 0, 5, 0, 0, 0, 0, 0, 0,   0, 1, 1);  // E and M both $5: E wins
    add(1, 5, 0, 0, 0, 5, 2, 0, 0, 0,   0, 2, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);  // young E tnew2 hides W
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0,   0, 0, 0);  // producer to $0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
    add(1, 0, 0, 0, 0, 7, 3, 0, 0, 0,   0, 0, 0);  // tnew 3 -> 2
    add(1, 7, 2, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
    add(1, 7, 1, 7, 0, 0, 0, 0, 0, 0,   1, 0, 0);
    add(1, 7, 0, 7, 0, 0, 0, 0, 0, 0,   0, 3, 3);
    add(1, 0, 0, 0, 0, 12, 2, 0, 0, 0,  0, 0, 0);
    add(1, 12, 0, 0, 0, 13, 0, 0, 0, 1, 1, 0, 0);  // stall + flush
    add(1, 13, 0, 0, 0, 14, 0, 0, 0, 1, 0, 0, 0);  // flush alone
    add(1, 14, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 15, 2, 0, 0, 0,  0, 0, 0);
    add(0, 15, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);  // invalid D never stalls
    add(1, 15, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    add(1, 15, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0);  // md_start
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0);  // md op meets md_start
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);  // non-md op while busy
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0);  // reload while busy
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0);

    e_data = E_VAL; m_data = M_VAL; w_data = W_VAL;
    d_rs_data = {RS1, RS0};
    z = '{default: '0};
    drive(z);
    reset = 1'b1;
    #12;
    check_all("reset", 1'b0, 2'd0, 2'd0);
    $display("reset stall=%0d sel=%0h", stall, fwd_sel);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_all($sformatf("step%0d", i), vecs[i].es, vecs[i].e0, vecs[i].e1);
      $display("step%0d v=%0d rs=%0d/%0d stall=%0d sel=%0d/%0d", i, vecs[i].v,
               vecs[i].ra0, vecs[i].ra1, stall, fwd_sel[1:0], fwd_sel[3:2]);
    end

    // Async reset in the middle of an md window with a load pending in E
    @(negedge clk);
    z = '{default: '0};
    z.v = 1; z.dst = 20; z.tn = 2; z.mds = 1;
    drive(z);
    #1;
    check_all("rst_a", 1'b0, 2'd0, 2'd0);
    $display("rst_a stall=%0d", stall);
    @(negedge clk);
    z = '{default: '0};
    z.v = 1; z.md = 1; z.ra0 = 20;
    drive(z);
    #1;
    check_all("rst_b", 1'b1, 2'd0, 2'd0);
    $display("rst_b stall=%0d", stall);
    #1 reset = 1'b1;
    #1;
    check_all("rst_c", 1'b0, 2'd0, 2'd0);
    $display("rst_c stall=%0d", stall);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("rst_d", 1'b0, 2'd0, 2'd0);
    $display("rst_d stall=%0d", stall);
    @(negedge clk);
    #1;
    check_all("rst_e", 1'b0, 2'd0, 2'd0);
    $display("rst_e stall=%0d", stall);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
